mod32_accum_ctrl: RTL



---
 rtl/mod32_pkg.sv | 17 +
 rtl/P2x4x4_adder.sv | 45 ++++
 rtl/mod32_accum_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mod32_pkg.sv
// Shared types and constants for the mod 2^32-1 accumulator slice.
package mod32_pkg;

    localparam int unsigned MOD32_W = 32;
    localparam logic [MOD32_W-1:0] MOD32_NEG_ZERO = 32'hFFFF_FFFF;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t HOLD = 2'd2;

    // Ones'-complement negative zero detect.
    function automatic logic is_neg_zero(input logic [MOD32_W-1:0] v);
        return v == MOD32_NEG_ZERO;
    endfunction

endpackage

// File: rtl/P2x4x4_adder.sv
// 32-bit end-around-carry prefix adder: sum = (a + b) mod (2^32 - 1).
module P2x4x4_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    localparam int unsigned W = 32;

    // One Kogge-Stone combine level at span d; returns {g, p}.
    function automatic logic [2*W-1:0] ks_step(input logic [W-1:0] g, input logic [W-1:0] p,
                                               input int d);
        logic [W-1:0] go;
        logic [W-1:0] po;
        for (int i = 0; i < int'(W); i++) begin
            if (i >= d) begin
                go[i] = g[i] | (p[i] & g[i-d]);
                po[i] = p[i] & p[i-d];
            end else begin
                go[i] = g[i];
                po[i] = p[i];
            end
        end
        return {go, po};
    endfunction

    logic [W-1:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4, g5, p5;
    logic [W-1:0] carry_full;
    logic [W-1:0] carry;

    always_comb begin
        g0 = a & b;
        p0 = a ^ b;
        {g1, p1} = ks_step(g0, p0, 1);
        {g2, p2} = ks_step(g1, p1, 2);
        {g3, p3} = ks_step(g2, p2, 4);
        {g4, p4} = ks_step(g3, p3, 8);
        {g5, p5} = ks_step(g4, p4, 16);
        // Carry-out of bit 31 re-enters through every propagating prefix.
        carry_full = g5 | (p5 & {W{g5[W-1]}});
        carry      = {carry_full[W-2:0], carry_full[W-1]};
        sum        = p0 ^ carry;
    end

endmodule

// File: rtl/mod32_accum_ctrl.sv
// Burst controller reducing operand words to a ones'-complement sum.
// Optional MOD32_ACCUM_ZERO_NORM_EN presents negative zero as 0x00000000.
module mod32_accum_ctrl
    import mod32_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MOD32_W-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MOD32_W-1:0]   out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [MOD32_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 sat_q, sat_d;
    logic                 accept;
    logic [MOD32_W-1:0]   add_a;
    logic [MOD32_W-1:0]   add_sum;
    logic [MOD32_W-1:0]   sum_pres;

    assign in_ready = (state_q != HOLD) && !clr;
    assign accept   = in_valid && in_ready;
    assign add_a    = (state_q == IDLE) ? '0 : acc_q;

    P2x4x4_adder u_adder (
        .a   (add_a),
        .b   (in_data),
        .sum (add_sum)
    );

    // Next-state, accumulator and counter update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = add_sum;
                    count_d = CNT_W'(1);
                    sat_d   = 1'b0;
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = add_sum;
                    if (count_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
                sat_d   = 1'b0;
            end
        endcase
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end
    end

`ifdef MOD32_ACCUM_ZERO_NORM_EN
    assign sum_pres = is_neg_zero(acc_d) ? '0 : acc_d;
`else
    assign sum_pres = acc_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Result registers load from next-state values so they appear with HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= (state_d == HOLD);
            out_sum   <= (state_d == HOLD) ? sum_pres : '0;
            out_count <= (state_d == HOLD) ? count_d : '0;
            out_sat   <= (state_d == HOLD) ? sat_d : 1'b0;
        end
    end

endmodule
